uart_packet_controller: RTL

- Sequences the UART byte receiver's data/data_valid/ready handshake.
- Frames the received byte stream into command packets: sync, cmd, len, payload, checksum.
- Writes payload bytes into an external packet buffer and presents one packet result to the command decoder with a valid/ack handshake.
- Sits between the UART receiver and the command layer. Reports length, checksum and inter-byte timeout errors.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_byte_handshake.sv | 36 +++
 rtl/uart_packet_controller.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: framer states, packet status
// codes and default timing constants.
package uart_pkg;

  typedef enum logic [2:0] {
    HUNT,
    CMD,
    LEN,
    PAYLOAD,
    CSUM,
    DONE
  } state_t;

  typedef logic [1:0] status_t;

  localparam status_t STATUS_OK       = 2'd0;
  localparam status_t STATUS_BAD_LEN  = 2'd1;
  localparam status_t STATUS_BAD_CSUM = 2'd2;
  localparam status_t STATUS_TIMEOUT  = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int         DEFAULT_MAX_LEN   = 16;

  // 9600 baud at 12 MHz; the inter-byte timeout is two 10-bit byte times.
  localparam int CYCLES_PER_BIT         = 1250;
  localparam int DEFAULT_TIMEOUT_CYCLES = 20 * CYCLES_PER_BIT;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
    return acc + data;
  endfunction

endpackage

// File: rtl/uart_byte_handshake.sv
// Turns the receiver's level-style data_valid into a single accept strobe per
// byte and generates the registered rx_ready pulse that acknowledges it.
module uart_byte_handshake
  import uart_pkg::*;
(
  input  logic       clock_12MHz,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  input  logic       enable,
  output logic       rx_ready,
  output logic       byte_stb,
  output logic [7:0] byte_data
);

  logic skip;

  assign byte_stb  = rx_ready & rx_data_valid;
  assign byte_data = rx_data;

  // The receiver keeps valid high for a cycle after it sees ready, so once a
  // byte is taken we wait for valid to be seen low before asking again.
  always_ff @(posedge clock_12MHz) begin
    if (reset) begin
      rx_ready <= 1'b0;
      skip     <= 1'b0;
    end else begin
      rx_ready <= rx_data_valid & enable & ~skip & ~rx_ready;
      if (byte_stb)
        skip <= 1'b1;
      else if (!rx_data_valid)
        skip <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_packet_controller.sv
// Frames accepted UART bytes into sync/cmd/len/payload/checksum packets,
// streams the payload to an external buffer and reports one result per packet.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   HUNT    | dropping bytes until SYNC_BYTE is seen
//   CMD     | next byte is the command
//   LEN     | next byte is the payload length (0..MAX_LEN)
//   PAYLOAD | writing payload bytes to the buffer
//   CSUM    | next byte is compared against the running checksum
//   DONE    | result presented on pkt_*, receiver back-pressured until ack
module uart_packet_controller
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         MAX_LEN        = DEFAULT_MAX_LEN,
  parameter int         TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clock_12MHz,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  output logic       rx_ready,
  output logic       pay_we,
  output logic [7:0] pay_addr,
  output logic [7:0] pay_wdata,
  output logic       pkt_valid,
  output logic [7:0] pkt_cmd,
  output logic [7:0] pkt_len,
  output logic [1:0] pkt_status,
  input  logic       pkt_ack
);

  localparam int         TMO_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] MAX_LEN_B   = 8'(MAX_LEN);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  state_t           state, state_next;
  logic [7:0]       csum, csum_next;
  logic [7:0]       idx, idx_next;
  logic [7:0]       cmd_next, len_next;
  status_t          status_q, status_next;
  logic [TMO_W-1:0] tmo_cnt, tmo_next;
  logic             we_next;
  logic [7:0]       addr_next, wdata_next;
  logic             in_packet;
  logic             timeout_hit;
  logic             hs_enable;
  logic             byte_stb;
  logic [7:0]       byte_data;

  // Stop asking for bytes both in DONE and on the cycle we are about to enter
  // it, so no byte is ever swallowed while a result is pending.
  assign hs_enable = (state != DONE) && (state_next != DONE);

  uart_byte_handshake u_handshake (
    .clock_12MHz   (clock_12MHz),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .enable        (hs_enable),
    .rx_ready      (rx_ready),
    .byte_stb      (byte_stb),
    .byte_data     (byte_data)
  );

  always_ff @(posedge clock_12MHz) begin
    if (reset) begin
      state      <= HUNT;
      csum       <= '0;
      idx        <= '0;
      pkt_cmd    <= '0;
      pkt_len    <= '0;
      status_q   <= STATUS_OK;
      tmo_cnt    <= '0;
      pay_we     <= 1'b0;
      pay_addr   <= '0;
      pay_wdata  <= '0;
    end else begin
      state      <= state_next;
      csum       <= csum_next;
      idx        <= idx_next;
      pkt_cmd    <= cmd_next;
      pkt_len    <= len_next;
      status_q   <= status_next;
      tmo_cnt    <= tmo_next;
      pay_we     <= we_next;
      pay_addr   <= addr_next;
      pay_wdata  <= wdata_next;
    end
  end

  always_comb begin
    state_next  = state;
    csum_next   = csum;
    idx_next    = idx;
    cmd_next    = pkt_cmd;
    len_next    = pkt_len;
    status_next = status_q;
    we_next     = 1'b0;
    addr_next   = pay_addr;
    wdata_next  = pay_wdata;
    tmo_next    = '0;

    in_packet   = (state == CMD) || (state == LEN) || (state == PAYLOAD) || (state == CSUM);
    timeout_hit = in_packet && !byte_stb && (tmo_cnt == TMO_LIMIT);

    if (in_packet && !byte_stb)
      tmo_next = tmo_cnt + TMO_W'(1);

    unique case (state)
      HUNT: begin
        if (byte_stb && byte_data == SYNC_BYTE) begin
          state_next  = CMD;
          csum_next   = '0;
          idx_next    = '0;
          cmd_next    = '0;
          len_next    = '0;
          status_next = STATUS_OK;
        end
      end
      CMD: begin
        if (byte_stb) begin
          cmd_next   = byte_data;
          csum_next  = byte_data;
          state_next = LEN;
        end
      end
      LEN: begin
        if (byte_stb) begin
          len_next  = byte_data;
          csum_next = csum_add(csum, byte_data);
          if (byte_data > MAX_LEN_B) begin
            state_next  = DONE;
            status_next = STATUS_BAD_LEN;
          end else if (byte_data == 8'd0) begin
            state_next = CSUM;
          end else begin
            state_next = PAYLOAD;
            idx_next   = '0;
          end
        end
      end
      PAYLOAD: begin
        if (byte_stb) begin
          we_next    = 1'b1;
          addr_next  = idx;
          wdata_next = byte_data;
          csum_next  = csum_add(csum, byte_data);
          idx_next   = idx + 8'd1;
          if (idx == pkt_len - 8'd1)
            state_next = CSUM;
        end
      end
      CSUM: begin
        if (byte_stb) begin
          state_next  = DONE;
          status_next = (byte_data == csum) ? STATUS_OK : STATUS_BAD_CSUM;
        end
      end
      DONE: begin
        if (pkt_ack)
          state_next = HUNT;
      end
      default: state_next = HUNT;
    endcase

    // An accept on the terminal-count cycle wins over the timeout.
    if (timeout_hit) begin
      state_next  = DONE;
      status_next = STATUS_TIMEOUT;
    end
  end

  assign pkt_valid  = (state == DONE);
  assign pkt_status = status_q;

endmodule
